song_ctrl: RTL and testbench

SONG_CTRL -- requirements
Module: song_ctrl

---
 rtl/song_ctrl_if.sv | 33 +++
 rtl/song_ctrl.sv | 139 +++++++++++++
 tb/tb_song_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/song_ctrl_if.sv
// rtl/song_ctrl_if.sv - button/mode/song_done inputs and display/player outputs of song_ctrl
interface song_ctrl_if;
    logic [2:0] button;
    logic [2:0] mode;
    logic       song_done;
    logic [2:0] song_num;
    logic       play_en;
    logic       song_restart;
    logic [3:0] disp_state;
    logic [3:0] disp_song;

    modport slave (
        input  button,
        input  mode,
        input  song_done,
        output song_num,
        output play_en,
        output song_restart,
        output disp_state,
        output disp_song
    );

    modport master (
        output button,
        output mode,
        output song_done,
        input  song_num,
        input  play_en,
        input  song_restart,
        input  disp_state,
        input  disp_song
    );
endinterface

// File: rtl/song_ctrl.sv
// rtl/song_ctrl.sv - button debouncing and IDLE/PLAY/PAUSE song selection controller
module song_ctrl #(
    parameter int SONG_NUM        = 4,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst_n,
    song_ctrl_if.slave ctrl
);
    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       SONG_LAST = 3'(SONG_NUM - 1);

    // Button bit positions
    localparam int B_PREV  = 0;
    localparam int B_PAUSE = 1;
    localparam int B_NEXT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d;
    logic [2:0]       press_q, press_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_t     state_q, state_d;
    logic [2:0] song_q, song_d;
    logic       restart_q, restart_d;
    logic       play_en_q;

    logic       auto_mode;
    logic [2:0] song_next;
    logic [2:0] song_prev;

    // Per-bit debouncer: count consecutive cycles the synchronized level differs
    // from the accepted level; accept it once the run reaches DEBOUNCE_CYCLES.
    always_comb begin
        deb_d   = deb_q;
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i]   = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizer, debounce and press-event registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= ctrl.button;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign auto_mode = (ctrl.mode == 3'b010);
    assign song_next = (song_q == SONG_LAST) ? 3'd0 : song_q + 3'd1;
    assign song_prev = (song_q == 3'd0) ? SONG_LAST : song_q - 3'd1;

    // Next state: leaving auto mode wins, then prev > next > pause > song_done
    always_comb begin
        state_d   = state_q;
        song_d    = song_q;
        restart_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (auto_mode) begin
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end
            end
            ST_PLAY, ST_PAUSE: begin
                if (!auto_mode) begin
                    state_d = ST_IDLE;
                end else if (press_q[B_PREV]) begin
                    song_d    = song_prev;
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end else if (press_q[B_NEXT]) begin
                    song_d    = song_next;
                    state_d   = ST_PLAY;
                    restart_d = 1'b1;
                end else if (press_q[B_PAUSE]) begin
                    state_d = (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;
                end else if (ctrl.song_done && state_q == ST_PLAY) begin
                    song_d    = song_next;
                    restart_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            song_q    <= 3'd0;
            restart_q <= 1'b0;
            play_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            song_q    <= song_d;
            restart_q <= restart_d;
            play_en_q <= (state_d == ST_PLAY);
        end
    end

    assign ctrl.song_num     = song_q;
    assign ctrl.play_en      = play_en_q;
    assign ctrl.song_restart = restart_q;
    assign ctrl.disp_state   = {2'b00, state_q};
    assign ctrl.disp_song    = {1'b0, song_q};
endmodule

// File: tb/tb_song_ctrl.sv
// tb/tb_song_ctrl.sv - randomized and directed self-checking bench for song_ctrl
module tb_song_ctrl;
    localparam int SN = 4;
    localparam int DB = 4;

    logic clk;
    logic rst_n;
    song_ctrl_if bus();

    song_ctrl #(.SONG_NUM(SN), .DEBOUNCE_CYCLES(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int rcnt     = 0;

    // Reference model: raw button delayed two samples, run-length debounce,
    // press event one cycle later, then the selection rules with modular song arithmetic.
    bit [2:0] m_s1, m_s2, m_deb, m_press, m_new;
    int       m_cnt [3];
    int       m_state;   // 0 idle, 1 play, 2 pause
    int       m_song;
    bit       m_restart;
    bit       m_valid = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_press = 0;
            for (int j = 0; j < 3; j++) m_cnt[j] = 0;
            m_state = 0; m_song = 0; m_restart = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_restart = 0;
            if (m_state == 0) begin
                if (bus.mode == 3'b010) begin m_state = 1; m_restart = 1; end
            end else if (bus.mode != 3'b010) begin
                m_state = 0;
            end else if (m_press[0]) begin
                m_song = (m_song + SN - 1) % SN; m_state = 1; m_restart = 1;
            end else if (m_press[2]) begin
                m_song = (m_song + 1) % SN; m_state = 1; m_restart = 1;
            end else if (m_press[1]) begin
                m_state = (m_state == 1) ? 2 : 1;
            end else if (bus.song_done && m_state == 1) begin
                m_song = (m_song + 1) % SN; m_restart = 1;
            end
            m_new = 0;
            for (int j = 0; j < 3; j++) begin
                if (m_s2[j] != m_deb[j]) begin
                    m_cnt[j]++;
                    if (m_cnt[j] == DB) begin
                        m_deb[j] = m_s2[j];
                        m_new[j] = m_s2[j];
                        m_cnt[j] = 0;
                    end
                end else begin
                    m_cnt[j] = 0;
                end
            end
            m_press = m_new;
            m_s2 = m_s1;
            m_s1 = bus.button;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_song_num", 32'(bus.song_num), 32'(m_song));
            chk("m_play_en", 32'(bus.play_en), 32'(m_state == 1));
            chk("m_restart", 32'(bus.song_restart), 32'(m_restart));
            chk("m_disp_state", 32'(bus.disp_state), 32'(m_state));
            chk("m_disp_song", 32'(bus.disp_song), 32'(m_song));
        end
        if (bus.song_restart === 1'b1) rcnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [2:0] b, input int hold);
        bus.button = b;
        repeat (hold) cyc();
        bus.button = 3'b000;
        repeat (8) cyc();
    endtask

    int rc0;
    int s0;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.button = 3'b000;
        bus.mode = 3'b000;
        bus.song_done = 1'b0;
        repeat (3) cyc();
        chk("rst_song", 32'(bus.song_num), 32'd0);
        chk("rst_play", 32'(bus.play_en), 32'd0);
        chk("rst_restart", 32'(bus.song_restart), 32'd0);
        chk("rst_disp_state", 32'(bus.disp_state), 32'd0);
        chk("rst_disp_song", 32'(bus.disp_song), 32'd0);

        rst_n = 1'b1;
        bus.mode = 3'b010;
        cyc();
        chk("auto_restart", 32'(bus.song_restart), 32'd1);
        chk("auto_play", 32'(bus.play_en), 32'd1);
        chk("auto_disp", 32'(bus.disp_state), 32'd1);
        chk("auto_song", 32'(bus.song_num), 32'd0);
        cyc();
        chk("auto_restart_once", 32'(bus.song_restart), 32'd0);

        repeat (3) press(3'b100, 8);
        chk("next3_song", 32'(bus.song_num), 32'd3);
        rc0 = rcnt;
        press(3'b100, 8);
        chk("next_wrap", 32'(bus.song_num), 32'd0);
        chk("next_wrap_pulses", 32'(rcnt - rc0), 32'd1);
        rc0 = rcnt;
        press(3'b001, 8);
        chk("prev_wrap", 32'(bus.song_num), 32'd3);
        chk("prev_wrap_pulses", 32'(rcnt - rc0), 32'd1);

        rc0 = rcnt;
        press(3'b010, 8);
        chk("pause_play_en", 32'(bus.play_en), 32'd0);
        chk("pause_disp", 32'(bus.disp_state), 32'd2);
        press(3'b010, 8);
        chk("resume_disp", 32'(bus.disp_state), 32'd1);
        chk("resume_play_en", 32'(bus.play_en), 32'd1);
        chk("pause_song", 32'(bus.song_num), 32'd3);
        chk("pause_no_restart", 32'(rcnt - rc0), 32'd0);

        rc0 = rcnt;
        for (int i = 0; i < 20; i++) begin
            bus.button = (i % 2 == 0) ? 3'b100 : 3'b000;
            cyc();
            cyc();
        end
        bus.button = 3'b000;
        repeat (8) cyc();
        chk("bounce_no_event", 32'(rcnt - rc0), 32'd0);
        chk("bounce_song", 32'(bus.song_num), 32'd3);
        rc0 = rcnt;
        press(3'b100, 25);
        chk("long_hold_one", 32'(rcnt - rc0), 32'd1);
        chk("long_hold_song", 32'(bus.song_num), 32'd0);

        press(3'b100, 8);
        chk("pre_prio_song", 32'(bus.song_num), 32'd1);
        bus.button = 3'b001;
        repeat (6) cyc();
        bus.song_done = 1'b1;
        cyc();
        bus.song_done = 1'b0;
        chk("prev_beats_done", 32'(bus.song_num), 32'd0);
        repeat (4) cyc();
        bus.button = 3'b000;
        repeat (8) cyc();
        chk("prio_settled", 32'(bus.song_num), 32'd0);

        press(3'b010, 8);
        bus.song_done = 1'b1;
        cyc();
        bus.song_done = 1'b0;
        cyc();
        chk("done_in_pause_state", 32'(bus.disp_state), 32'd2);
        chk("done_in_pause_song", 32'(bus.song_num), 32'd0);
        press(3'b010, 8);

        press(3'b100, 8);
        press(3'b100, 8);
        chk("pre_idle_song", 32'(bus.song_num), 32'd2);
        bus.mode = 3'b011;
        cyc();
        chk("idle_play_en", 32'(bus.play_en), 32'd0);
        chk("idle_disp", 32'(bus.disp_state), 32'd0);
        bus.mode = 3'b010;
        cyc();
        chk("reauto_play", 32'(bus.play_en), 32'd1);
        chk("reauto_restart", 32'(bus.song_restart), 32'd1);
        chk("reauto_song", 32'(bus.song_num), 32'd2);
        cyc();
        rst_n = 1'b0;
        cyc();
        chk("midrst_song", 32'(bus.song_num), 32'd0);
        chk("midrst_play", 32'(bus.play_en), 32'd0);
        chk("midrst_disp", 32'(bus.disp_state), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) bus.button = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 59) == 0)
                bus.mode = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            bus.song_done = ($urandom_range(0, 7) == 0);
            rst_n = ($urandom_range(0, 699) != 0);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
